// File: rtl/hs32_pipe_chain_if.sv
// Handshake and stage-tap bundle for hs32_pipe_chain.
// The master side is the pipeline's environment; the slave side is the chain itself.
interface hs32_pipe_chain_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) ();
   localparam int unsigned CW = $clog2(2 * STAGES + 1);

   logic                        in_valid;
   logic                        in_ready;
   logic [WIDTH-1:0]            in_data;
   logic [STAGES-1:0]           stg_vld;
   logic [STAGES*WIDTH-1:0]     stg_data;
   logic [(STAGES-1)*WIDTH-1:0] xf_data;
   logic [STAGES-1:0]           stall;
   logic                        flush;
   logic [STAGES-1:0]           flush_mask;
   logic                        out_valid;
   logic                        out_ready;
   logic [WIDTH-1:0]            out_data;
   logic [CW-1:0]               count;

   modport master (
      output in_valid, in_data, xf_data, stall, flush, flush_mask, out_ready,
      input  in_ready, stg_vld, stg_data, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, xf_data, stall, flush, flush_mask, out_ready,
      output in_ready, stg_vld, stg_data, out_valid, out_data, count
   );
endinterface

// File: rtl/hs32_pipe_chain.sv
// Elastic valid/ready pipeline backbone: STAGES registered stages with optional skid slot,
// per-stage hazard stall, masked flush and live-entry count.
module hs32_pipe_chain #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4,
   parameter int unsigned SKID   = 1
) (
   input logic              clk,
   input logic              reset,
   hs32_pipe_chain_if.slave bus
);
   localparam int unsigned CW = $clog2(2 * STAGES + 1);

   logic [STAGES-1:0]            v_q, v_d, sv_q, sv_d;
   logic [STAGES-1:0][WIDTH-1:0] d_q, d_d, sd_q, sd_d;
   logic [STAGES-1:0][WIDTH-1:0] in_d;
   logic [STAGES-1:0]            ov, adv, acc, kill;
   logic [STAGES:0]              rdy;
   logic [CW-1:0]                count_q, count_d;

   // Ready is resolved from the output back to stage 0 so the SKID=0 chain stays combinational.
   always_comb begin
      ov           = v_q & ~bus.stall;
      kill         = bus.flush_mask & {STAGES{bus.flush}};
      adv          = '0;
      rdy          = '0;
      rdy[STAGES]  = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = ov[k] & rdy[k+1];
         if (SKID != 0) begin
            rdy[k] = ~sv_q[k];
         end else begin
            rdy[k] = ~v_q[k] | adv[k];
         end
      end
   end

   always_comb begin
      in_d    = '0;
      acc     = '0;
      in_d[0] = bus.in_data;
      acc[0]  = bus.in_valid & rdy[0];
      for (int k = 1; k < STAGES; k++) begin
         in_d[k] = bus.xf_data[(k-1)*WIDTH +: WIDTH];
         acc[k]  = ov[k-1] & rdy[k];
      end
   end

   always_comb begin
      v_d  = v_q;
      sv_d = sv_q;
      d_d  = d_q;
      sd_d = sd_q;
      for (int k = 0; k < STAGES; k++) begin
         if (SKID != 0) begin
            if (adv[k]) begin
               // Skid holds the older item, so it refills main before any new arrival.
               if (sv_q[k]) begin
                  v_d[k]  = 1'b1;
                  d_d[k]  = sd_q[k];
                  sv_d[k] = 1'b0;
               end else begin
                  v_d[k] = acc[k];
                  d_d[k] = in_d[k];
               end
            end else if (acc[k]) begin
               if (v_q[k]) begin
                  sv_d[k] = 1'b1;
                  sd_d[k] = in_d[k];
               end else begin
                  v_d[k] = 1'b1;
                  d_d[k] = in_d[k];
               end
            end
         end else begin
            sv_d[k] = 1'b0;
            if (acc[k]) begin
               v_d[k] = 1'b1;
               d_d[k] = in_d[k];
            end else if (adv[k]) begin
               v_d[k] = 1'b0;
            end
         end
         if (kill[k]) begin
            v_d[k]  = 1'b0;
            sv_d[k] = 1'b0;
         end
      end
   end

   always_comb begin
      count_d = '0;
      for (int k = 0; k < STAGES; k++) begin
         count_d = count_d + CW'(v_d[k]) + CW'(sv_d[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q     <= '0;
         sv_q    <= '0;
         count_q <= '0;
      end else begin
         v_q     <= v_d;
         sv_q    <= sv_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      d_q  <= d_d;
      sd_q <= sd_d;
   end

   assign bus.in_ready  = rdy[0];
   assign bus.stg_vld   = v_q;
   assign bus.stg_data  = d_q;
   assign bus.out_valid = ov[STAGES-1];
   assign bus.out_data  = d_q[STAGES-1];
   assign bus.count     = count_q;
endmodule
